// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means (k=3, n=2) centroid update path.
package kmeans_pkg;

    localparam int NUM_CENTROIDS  = 3;
    localparam int CENTROID_IDX_W = 2;

    typedef logic [CENTROID_IDX_W-1:0] centroid_idx_t;

    localparam centroid_idx_t LAST_CENTROID = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DIV   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } kmeans_state_t;

endpackage

// File: rtl/kmeans_seq_divider.sv
// Restoring sequential divider: one quotient bit per cycle, MSB first.
// Operands are latched on start. done is high during the final iteration,
// and quotient then presents the completed result, so a consumer can
// register it on the same edge that retires the divider.
module kmeans_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH:0]   shifted, trial;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_q};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CW'(1));
    assign quotient = quo_nxt;

    // Operand latch on start, then iterate with a down-counter until terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(WIDTH);
            rem_q  <= '0;
            quo_q  <= dividend;
            div_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/kmeans_centroid_update_k3n2.sv
// Walks centroids 0..2 after an accumulation pass, divides each accumulator
// by its point count and strobes the new coordinates to the centroid registers.
//
//   state | meaning
//   IDLE  | waiting for start
//   READ  | acc read port driven for idx; operands captured at end of cycle
//   DIV   | both dividers iterating (skipped when count is 0)
//   WRITE | wr_en strobe for idx; advance to next centroid or finish
//   DONE  | one-cycle done pulse, then back to IDLE
module kmeans_centroid_update_k3n2
    import kmeans_pkg::*;
#(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                rd_acc_en,
    output logic [CENTROID_IDX_W-1:0]           rd_acc_centroid,
    input  logic [acc_width-1:0]                acc0_in,
    input  logic [acc_width-1:0]                acc1_in,
    input  logic [input_data_qty_bit_width-1:0] count_in,
    output logic                                wr_en,
    output logic [CENTROID_IDX_W-1:0]           wr_centroid,
    output logic                                wr_keep,
    output logic [input_data_width-1:0]         wr_d0,
    output logic [input_data_width-1:0]         wr_d1,
    output logic                                busy,
    output logic                                done
);

    kmeans_state_t state, state_nxt;
    centroid_idx_t idx_q, wr_centroid_q;
    logic          keep_q;
    logic [input_data_width-1:0] wr_d0_q, wr_d1_q, sat0, sat1;

    logic                 count_zero, div_start;
    logic                 div_busy0, div_busy1, div_done0, div_done1, div_done_both;
    logic [acc_width-1:0] divisor, quo0, quo1;
    logic                 load_wr;

    assign count_zero    = (count_in == '0);
    assign divisor       = {{(acc_width - input_data_qty_bit_width){1'b0}}, count_in};
    assign div_done_both = div_done0 && div_done1;

    kmeans_seq_divider #(.WIDTH(acc_width)) u_div0 (
        .clk(clk), .rst(rst), .start(div_start), .dividend(acc0_in), .divisor(divisor),
        .busy(div_busy0), .done(div_done0), .quotient(quo0)
    );

    kmeans_seq_divider #(.WIDTH(acc_width)) u_div1 (
        .clk(clk), .rst(rst), .start(div_start), .dividend(acc1_in), .divisor(divisor),
        .busy(div_busy1), .done(div_done1), .quotient(quo1)
    );

    // Quotients that do not fit a coordinate clamp to all-ones.
    always_comb begin
        sat0 = (|quo0[acc_width-1:input_data_width]) ? '1 : quo0[input_data_width-1:0];
        sat1 = (|quo1[acc_width-1:input_data_width]) ? '1 : quo1[input_data_width-1:0];
    end

    // Next-state logic; dividers are kicked on the READ edge when count is nonzero.
    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ: begin
                if (count_zero) begin
                    state_nxt = ST_WRITE;
                end else begin
                    div_start = 1'b1;
                    state_nxt = ST_DIV;
                end
            end
            // Falling out of DIV with neither divider busy is only a recovery path.
            ST_DIV:   if (div_done_both || !(div_busy0 || div_busy1)) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (idx_q == LAST_CENTROID) ? ST_DONE : ST_READ;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Result registers load only on the edge entering WRITE so they hold elsewhere.
    assign load_wr = ((state == ST_READ) && count_zero) || ((state == ST_DIV) && div_done_both);

    // Centroid index and write-result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            keep_q        <= 1'b0;
            wr_centroid_q <= '0;
            wr_d0_q       <= '0;
            wr_d1_q       <= '0;
        end else begin
            if (load_wr) begin
                wr_centroid_q <= idx_q;
                keep_q        <= (state == ST_READ);
                wr_d0_q       <= (state == ST_READ) ? '0 : sat0;
                wr_d1_q       <= (state == ST_READ) ? '0 : sat1;
            end
            if (state == ST_WRITE)
                idx_q <= (idx_q == LAST_CENTROID) ? '0 : idx_q + 2'd1;
        end
    end

    assign rd_acc_en       = (state == ST_READ) || (state == ST_DIV) || (state == ST_WRITE);
    assign rd_acc_centroid = rd_acc_en ? idx_q : '0;
    assign wr_en           = (state == ST_WRITE);
    assign wr_keep         = (state == ST_WRITE) && keep_q;
    assign wr_centroid     = wr_centroid_q;
    assign wr_d0           = wr_d0_q;
    assign wr_d1           = wr_d1_q;
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_DONE);

endmodule

// File: tb/tb_kmeans_centroid_update_k3n2.sv
// Directed bench for the centroid update block with a behavioural acc-block read model.
module tb_kmeans_centroid_update_k3n2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rd_acc_en;
    logic [1:0]  rd_acc_centroid;
    logic [15:0] acc0_in, acc1_in;
    logic [7:0]  count_in;
    logic        wr_en, wr_keep, busy, done;
    logic [1:0]  wr_centroid;
    logic [7:0]  wr_d0, wr_d1;

    logic [15:0] m_acc0 [3];
    logic [15:0] m_acc1 [3];
    logic [7:0]  m_cnt  [3];

    int exp_cyc [3];
    int exp_keep[3];
    int exp_d0  [3];
    int exp_d1  [3];
    int exp_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign acc0_in  = (rd_acc_centroid == 2'd3) ? '0 : m_acc0[rd_acc_centroid];
    assign acc1_in  = (rd_acc_centroid == 2'd3) ? '0 : m_acc1[rd_acc_centroid];
    assign count_in = (rd_acc_centroid == 2'd3) ? '0 : m_cnt[rd_acc_centroid];

    kmeans_centroid_update_k3n2 dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_acc_en(rd_acc_en), .rd_acc_centroid(rd_acc_centroid),
        .acc0_in(acc0_in), .acc1_in(acc1_in), .count_in(count_in),
        .wr_en(wr_en), .wr_centroid(wr_centroid), .wr_keep(wr_keep),
        .wr_d0(wr_d0), .wr_d1(wr_d1), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_vec(input int i, input int a0, input int a1, input int cnt,
                           input int cyc, input int keep, input int d0, input int d1);
        m_acc0[i]   = 16'(a0);
        m_acc1[i]   = 16'(a1);
        m_cnt[i]    = 8'(cnt);
        exp_cyc[i]  = cyc;
        exp_keep[i] = keep;
        exp_d0[i]   = d0;
        exp_d1[i]   = d1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_keep"}, wr_keep, 0);
        chk({tag, "_rd_en"}, rd_acc_en, 0);
        chk({tag, "_rd_idx"}, rd_acc_centroid, 0);
        chk({tag, "_wr_idx"}, wr_centroid, 0);
        chk({tag, "_d0"}, wr_d0, 0);
        chk({tag, "_d1"}, wr_d1, 0);
    endtask

    // Cycle 1 is the cycle after the edge that samples start; sampling is at negedges.
    task automatic run_pass(input bit restart);
        int c, nwr, ndone;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 1; nwr = 0; ndone = 0;
        while (c <= exp_done + 6) begin
            if (c == 1) begin
                chk("read0_en", rd_acc_en, 1);
                chk("read0_idx", rd_acc_centroid, 0);
            end
            if (wr_en) begin
                if (nwr < 3) begin
                    chk("wr_cycle", c, exp_cyc[nwr]);
                    chk("wr_centroid", wr_centroid, nwr);
                    chk("wr_keep", wr_keep, exp_keep[nwr]);
                    chk("wr_d0", wr_d0, exp_d0[nwr]);
                    chk("wr_d1", wr_d1, exp_d1[nwr]);
                end
                nwr++;
            end
            if (done) begin
                chk("done_cycle", c, exp_done);
                ndone++;
            end
            start = (restart && (c == 5 || c == 30));
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("wr_count", nwr, 3);
        chk("done_count", ndone, 1);
        chk("idle_after", busy, 0);
    endtask

    // Per-cycle protocol checker.
    logic p_wr = 1'b0, p_rd = 1'b0;
    logic [1:0] p_idx = 2'd0;
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) chk("wr_en_width", p_wr, 0);
            if (wr_en || done) chk("busy_cover", busy, 1);
            if (done) chk("done_wr_excl", wr_en, 0);
            if (rd_acc_en && p_rd && !p_wr) chk("rd_idx_stable", rd_acc_centroid, p_idx);
        end
        p_wr  = wr_en;
        p_rd  = rd_acc_en;
        p_idx = rd_acc_centroid;
    end

    initial begin
        int nwr, ndone;
        for (int i = 0; i < 3; i++) set_vec(i, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal pass, includes a quotient of exactly 255.
        set_vec(0, 300, 90, 10, 18, 0, 30, 9);
        set_vec(1, 40, 12, 4, 36, 0, 10, 3);
        set_vec(2, 510, 2, 2, 54, 0, 255, 1);
        exp_done = 55;
        run_pass(1'b0);

        // Empty middle centroid: 2-cycle slot with keep.
        set_vec(1, 40, 12, 0, 20, 1, 0, 0);
        set_vec(2, 510, 2, 2, 38, 0, 255, 1);
        exp_done = 39;
        run_pass(1'b0);

        // Saturation and floor boundaries.
        set_vec(0, 16'hFFFF, 5, 1, 18, 0, 255, 5);
        set_vec(1, 7, 8, 3, 36, 0, 2, 2);
        set_vec(2, 256, 255, 1, 54, 0, 255, 255);
        exp_done = 55;
        run_pass(1'b0);

        // start pulses while busy are ignored.
        set_vec(0, 300, 90, 10, 18, 0, 30, 9);
        set_vec(1, 40, 12, 4, 36, 0, 10, 3);
        set_vec(2, 510, 2, 2, 54, 0, 255, 1);
        exp_done = 55;
        run_pass(1'b1);

        // Reset in the middle of centroid 1's divide.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (24) @(negedge clk);
        chk("mid_div_busy", busy, 1);
        chk("mid_div_idx", rd_acc_centroid, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk); rst = 1'b0;
        nwr = 0; ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (wr_en) nwr++;
            if (done) ndone++;
        end
        chk("post_rst_wr", nwr, 0);
        chk("post_rst_done", ndone, 0);
        run_pass(1'b0);

        // start held high: IDLE for one cycle after DONE, then a new pass.
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        repeat (54) @(negedge clk);
        chk("held_done", done, 1);
        @(negedge clk);
        chk("held_idle", busy, 0);
        @(negedge clk);
        chk("held_restart_busy", busy, 1);
        chk("held_restart_rd", rd_acc_en, 1);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
